// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO timer peripheral: register offsets, TCON bit
// positions and address-window helpers.
package mmio_pkg;

  localparam int DATA_W = 32;
  localparam int OFF_W  = 8;
  localparam int LED_W  = 8;
  localparam int SW_W   = 8;
  localparam int DIGI_W = 12;

  localparam logic [DATA_W-1:0] WINDOW_MASK = 32'hFFFF_FF00;
  localparam logic [OFF_W-1:0]  WORD_MASK   = 8'hFC;

  localparam logic [OFF_W-1:0] OFF_TH      = 8'h00;
  localparam logic [OFF_W-1:0] OFF_TL      = 8'h04;
  localparam logic [OFF_W-1:0] OFF_TCON    = 8'h08;
  localparam logic [OFF_W-1:0] OFF_LED     = 8'h0C;
  localparam logic [OFF_W-1:0] OFF_SWITCH  = 8'h10;
  localparam logic [OFF_W-1:0] OFF_DIGI    = 8'h14;
  localparam logic [OFF_W-1:0] OFF_SYSTICK = 8'h18;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  function automatic logic window_hit(input logic [DATA_W-1:0] addr,
                                      input logic [DATA_W-1:0] base);
    return (addr & WINDOW_MASK) == (base & WINDOW_MASK);
  endfunction

endpackage

// File: rtl/mmio_interval_timer.sv
// Reloadable 32-bit interval timer (TH reload, TL count, TCON control/status)
// with a bus-write side port; bus writes take priority over counting.
module mmio_interval_timer
  import mmio_pkg::*;
#(
  parameter logic [DATA_W-1:0] TH_RESET = 32'h0000_0000,
  parameter logic [DATA_W-1:0] TL_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_th,
  input  logic              wr_tl,
  input  logic              wr_tcon,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] th,
  output logic [DATA_W-1:0] tl,
  output logic [2:0]        tcon,
  output logic              irqout
);

  logic [DATA_W-1:0] th_q;
  logic [DATA_W-1:0] tl_q;
  logic              en_q;
  logic              ie_q;
  logic              is_q;
  logic              ovf;
  logic              ovf_set;

  assign ovf     = en_q && (tl_q == '1);
  assign ovf_set = ovf && ie_q;

  // An overflow in the same cycle as a TCON write is ORed into the new status
  // so software can never clear an interrupt it has not yet seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q <= TH_RESET;
      tl_q <= TL_RESET;
      en_q <= 1'b0;
      ie_q <= 1'b0;
      is_q <= 1'b0;
    end else begin
      if (wr_th) th_q <= write_data;

      if (wr_tl)      tl_q <= write_data;
      else if (ovf)   tl_q <= th_q;
      else if (en_q)  tl_q <= tl_q + 1'b1;

      if (wr_tcon) begin
        en_q <= write_data[TCON_EN];
        ie_q <= write_data[TCON_IE];
        is_q <= write_data[TCON_IS] | ovf_set;
      end else if (ovf_set) begin
        is_q <= 1'b1;
      end
    end
  end

  assign th     = th_q;
  assign tl     = tl_q;
  assign tcon   = {is_q, ie_q, en_q};
  assign irqout = is_q & ie_q;

endmodule

// File: rtl/mmio_timer_peripheral.sv
// MMIO slave: address decode, LED/DIGI registers, switch synchronizer, read mux
// and interval timer. Define MMIO_SYSTICK_EN to add the free-running SYSTICK.
module mmio_timer_peripheral
  import mmio_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [DATA_W-1:0] TH_RESET  = 32'h0000_0000,
  parameter logic [DATA_W-1:0] TL_RESET  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] read_data,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  logic              hit;
  logic [OFF_W-1:0]  off;
  logic              wr;
  logic [DATA_W-1:0] th;
  logic [DATA_W-1:0] tl;
  logic [2:0]        tcon;
  logic [SW_W-1:0]   sw_p0;
  logic [SW_W-1:0]   sw_p1;

  assign hit = window_hit(address, BASE_ADDR);
  assign off = address[OFF_W-1:0] & WORD_MASK;
  assign wr  = mem_write && hit;

  mmio_interval_timer #(
    .TH_RESET(TH_RESET),
    .TL_RESET(TL_RESET)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_th     (wr && (off == OFF_TH)),
    .wr_tl     (wr && (off == OFF_TL)),
    .wr_tcon   (wr && (off == OFF_TCON)),
    .write_data(write_data),
    .th        (th),
    .tl        (tl),
    .tcon      (tcon),
    .irqout    (irqout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (wr && (off == OFF_LED))  led  <= write_data[LED_W-1:0];
      if (wr && (off == OFF_DIGI)) digi <= write_data[DIGI_W-1:0];
    end
  end

  // Two-flop synchronizer stages for the asynchronous board switches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= switch;
      sw_p1 <= sw_p0;
    end
  end

`ifdef MMIO_SYSTICK_EN
  logic [DATA_W-1:0] systick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) systick <= '0;
    else       systick <= systick + 1'b1;
  end
`endif

  always_comb begin
    read_data = '0;
    if (mem_read && hit) begin
      case (off)
        OFF_TH:      read_data = th;
        OFF_TL:      read_data = tl;
        OFF_TCON:    read_data = {{(DATA_W-3){1'b0}}, tcon};
        OFF_LED:     read_data = {{(DATA_W-LED_W){1'b0}}, led};
        OFF_SWITCH:  read_data = {{(DATA_W-SW_W){1'b0}}, sw_p1};
        OFF_DIGI:    read_data = {{(DATA_W-DIGI_W){1'b0}}, digi};
`ifdef MMIO_SYSTICK_EN
        OFF_SYSTICK: read_data = systick;
`endif
        default:     read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer_peripheral.sv
// Scoreboard bench for mmio_timer_peripheral: directed and random bus traffic
// against a behavioural model; a negedge monitor pops and compares expectations.
module tb_mmio_timer_peripheral;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [7:0]  switch = '0;
  logic [31:0] read_data;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;
  logic        probe = 1'b0;

  int total = 0;
  int bad = 0;

  mmio_timer_peripheral dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write_data(write_data),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .read_data (read_data),
    .switch    (switch),
    .led       (led),
    .digi      (digi),
    .irqout    (irqout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];

  // Behavioural model state
  logic [31:0] m_th, m_tl, m_sys;
  logic        m_en, m_ie, m_is;
  logic [7:0]  m_led, m_s0, m_s1;
  logic [11:0] m_digi;

  function automatic void model_reset();
    m_th = 32'h0; m_tl = 32'h0; m_sys = 32'h0;
    m_en = 1'b0; m_ie = 1'b0; m_is = 1'b0;
    m_led = 8'h0; m_s0 = 8'h0; m_s1 = 8'h0; m_digi = 12'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
    if (!rd || a[31:8] != B[31:8]) return 32'h0;
    case (a[7:2])
      6'd0: return m_th;
      6'd1: return m_tl;
      6'd2: return {29'h0, m_is, m_ie, m_en};
      6'd3: return {24'h0, m_led};
      6'd4: return {24'h0, m_s1};
      6'd5: return {20'h0, m_digi};
`ifdef MMIO_SYSTICK_EN
      6'd6: return m_sys;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model across one rising edge given that cycle's bus request
  function automatic void model_edge(input logic wr, input logic [31:0] a,
                                     input logic [31:0] wd);
    logic hit, ovf, set;
    logic [5:0] o;
    if (reset) begin
      model_reset();
      return;
    end
    hit = wr && (a[31:8] == B[31:8]);
    o   = a[7:2];
    ovf = m_en && (m_tl == 32'hFFFF_FFFF);
    set = ovf && m_ie;
    if (hit && o == 6'd1)  m_tl = wd;
    else if (ovf)          m_tl = m_th;
    else if (m_en)         m_tl = m_tl + 32'd1;
    if (hit && o == 6'd2) begin
      m_is = wd[2] | set;
      m_ie = wd[1];
      m_en = wd[0];
    end else begin
      m_is = m_is | set;
    end
    if (hit && o == 6'd0) m_th = wd;
    if (hit && o == 6'd3) m_led = wd[7:0];
    if (hit && o == 6'd5) m_digi = wd[11:0];
    m_s1  = m_s0;
    m_s0  = switch;
    m_sys = m_sys + 32'd1;
  endfunction

  function automatic void push_chk(input int sel, input logic [31:0] v, input string n);
    chk_t e;
    e.sel = sel; e.exp = v; e.name = n;
    q.push_back(e);
  endfunction

  task automatic cyc(input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] wd, input logic chk);
    mem_write = wr; mem_read = rd; address = a; write_data = wd; probe = chk;
    if (rd || chk) push_chk(0, m_read(rd, a), $sformatf("read@%h", a));
    if (chk) begin
      push_chk(1, {31'h0, m_is & m_ie}, "irqout");
      push_chk(2, {24'h0, m_led}, "led");
      push_chk(3, {20'h0, m_digi}, "digi");
    end
    @(negedge clk);
    @(posedge clk);
    model_edge(wr, a, wd);
    #1;
    mem_write = 1'b0; mem_read = 1'b0; probe = 1'b0;
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    model_reset();
    mem_read = 1'b1; address = B + 32'h4; probe = 1'b1;
    push_chk(0, m_read(1'b1, B + 32'h4), "reset_tl");
    push_chk(1, 32'h0, "reset_irqout");
    push_chk(2, 32'h0, "reset_led");
    push_chk(3, 32'h0, "reset_digi");
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0; mem_read = 1'b0; probe = 1'b0;
  endtask

  always @(negedge clk) begin
    if (probe || mem_read) begin
      while (q.size() > 0) begin
        chk_t e;
        logic [31:0] act;
        e = q.pop_front();
        case (e.sel)
          0:       act = read_data;
          1:       act = {31'h0, irqout};
          2:       act = {24'h0, led};
          default: act = {20'h0, digi};
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s got=%h want=%h t=%0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    logic w, rd;
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset values
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, B + 32'(i * 4), 32'h0, 1'b1);

    // reload and interrupt
    cyc(1'b1, 1'b0, B + 32'h0, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h4, 32'hFFFF_FFFE, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h8, 32'h3, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, B + 32'h4, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, B + 32'h8, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, B + 32'h8, 32'h3, 1'b1);
    cyc(1'b0, 1'b1, B + 32'h8, 32'h0, 1'b1);

    // masked overflow
    cyc(1'b1, 1'b0, B + 32'h8, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h4, 32'hFFFF_FFFE, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h8, 32'h1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, B + 32'h4, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, B + 32'h8, 32'h0, 1'b1);

    // TCON write in the overflow cycle
    cyc(1'b1, 1'b0, B + 32'h8, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h4, 32'hFFFF_FFFE, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h8, 32'h3, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, B + 32'h8, 32'h3, 1'b1);
    cyc(1'b0, 1'b1, B + 32'h8, 32'h0, 1'b1);

    // TL and TH writes in overflow cycles
    cyc(1'b1, 1'b0, B + 32'h4, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h4, 32'h5, 1'b0);
    cyc(1'b0, 1'b1, B + 32'h4, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, B + 32'h4, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h0, 32'h10, 1'b0);
    cyc(1'b0, 1'b1, B + 32'h4, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, B + 32'h0, 32'h0, 1'b1);

    // TH all ones: overflow every cycle
    cyc(1'b1, 1'b0, B + 32'h0, 32'hFFFF_FFFF, 1'b0);
    repeat (3) begin
      cyc(1'b1, 1'b0, B + 32'h8, 32'h3, 1'b1);
      cyc(1'b0, 1'b1, B + 32'h8, 32'h0, 1'b1);
    end

    // bus map
    cyc(1'b1, 1'b0, B + 32'hC, 32'h0000_00A5, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h14, 32'h0000_0FFF, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, B + 32'h20, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'h5000_0000, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, B + 32'hF, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, B + 32'h10, 32'hFF, 1'b0);
    switch = 8'h3C;
    repeat (3) cyc(1'b0, 1'b1, B + 32'h10, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, B + 32'h0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, B + 32'hC, 32'h5A, 1'b1);
    cyc(1'b0, 1'b1, B + 32'hC, 32'h0, 1'b1);

    // SYSTICK window
    cyc(1'b0, 1'b1, B + 32'h18, 32'h0, 1'b1);
    repeat (7) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h18, 32'h1234, 1'b0);
    cyc(1'b0, 1'b1, B + 32'h18, 32'h0, 1'b1);

    // reset in the middle of a count with an interrupt pending
    cyc(1'b1, 1'b0, B + 32'h8, 32'h3, 1'b0);
    cyc(1'b1, 1'b0, B + 32'h4, 32'h1234, 1'b0);
    cyc(1'b0, 1'b1, B + 32'h4, 32'h0, 1'b1);
    mid_reset();
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, B + 32'(i * 4), 32'h0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 15);
      a  = B + 32'($urandom_range(0, 8) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a ^ (32'h1 << $urandom_range(8, 31));
      w  = (r < 6);
      rd = (r >= 4 && r < 12);
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        2:       d = 32'($urandom_range(0, 7));
        default: d = 32'h3;
      endcase
      if ($urandom_range(0, 3) == 0) switch = 8'($urandom);
      cyc(w, rd, a, d, 1'b1);
    end

    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
